affine_io_sequencer: RTL

- Front-end controller for the picoMIPS affine-transform datapath; sequences the user switch/button protocol around the processor.
- Synchronises and debounces the handshake button, then captures x1 and y1 from the data switches on successive presses.
- Issues a one-cycle start to the datapath, waits for done, then shows x2 and y2 on the LEDs, one per press.
- Sits between the top-level SW/LED pins and the picoMIPS core.

---
 rtl/affine_io_sequencer_if.sv | 31 +++
 rtl/affine_io_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/affine_io_sequencer_if.sv
// Bundle of the switch/LED pins and the picoMIPS datapath handshake.
//   sw_data, sw_btn : user data switches and raw handshake button
//   x_out, y_out    : captured operands to the datapath
//   start           : one-cycle "operands valid" pulse to the datapath
//   done            : datapath result-valid strobe, res_x/res_y valid with it
//   led, phase      : display value and FSM state for debug LEDs
// master = sequencer side, slave = board/datapath side.
interface affine_io_sequencer_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] sw_data;
   logic              sw_btn;
   logic [DATA_W-1:0] x_out;
   logic [DATA_W-1:0] y_out;
   logic              start;
   logic              done;
   logic [DATA_W-1:0] res_x;
   logic [DATA_W-1:0] res_y;
   logic [DATA_W-1:0] led;
   logic [2:0]        phase;

   modport master (
      input  sw_data, sw_btn, done, res_x, res_y,
      output x_out, y_out, start, led, phase
   );

   modport slave (
      output sw_data, sw_btn, done, res_x, res_y,
      input  x_out, y_out, start, led, phase
   );
endinterface

// File: rtl/affine_io_sequencer.sv
// Front-end sequencer for the picoMIPS affine-transform datapath.
// Debounces the handshake button, captures x1/y1 on successive presses,
// pulses start, waits for done, then shows x2 and y2 on the LEDs.
//   fastclk : system clock
//   reset   : asynchronous active-high reset
//   io      : switch/LED/datapath bundle (master side)
//
// state  | meaning
// WAIT_X | waiting for press to capture x1; led shows stored y2
// WAIT_Y | waiting for press to capture y1; led shows x1
// START  | single-cycle start pulse to the datapath
// BUSY   | waiting for done; led shows x1
// SHOW_X | led shows x2; press returns to WAIT_X showing y2
module affine_io_sequencer #(
   parameter int DEBOUNCE_CYCLES = 2,
   parameter int DATA_W          = 8
) (
   input  logic                  fastclk,
   input  logic                  reset,
   affine_io_sequencer_if.master io
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [2:0] WAIT_X = 3'd0;
   localparam logic [2:0] WAIT_Y = 3'd1;
   localparam logic [2:0] START  = 3'd2;
   localparam logic [2:0] BUSY   = 3'd3;
   localparam logic [2:0] SHOW_X = 3'd4;

   logic             s1, s2, deb, deb_q;
   logic [CNT_W-1:0] cnt;
   logic             press;

   logic [2:0]        state;
   logic [DATA_W-1:0] x_q, y_q, ry_q, led_q;

   // The counter only runs while the synchronised level disagrees with the
   // debounced one, so any bounce back restarts the qualification window.
   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         deb   <= 1'b0;
         deb_q <= 1'b0;
         cnt   <= '0;
      end else begin
         s1    <= io.sw_btn;
         s2    <= s1;
         deb_q <= deb;
         if (s2 == deb) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign press = deb & ~deb_q;

   // led is updated on the edge each state is entered.
   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         state <= WAIT_X;
         x_q   <= '0;
         y_q   <= '0;
         ry_q  <= '0;
         led_q <= '0;
      end else begin
         case (state)
            WAIT_X: begin
               if (press) begin
                  x_q   <= io.sw_data;
                  led_q <= io.sw_data;
                  state <= WAIT_Y;
               end
            end
            WAIT_Y: begin
               if (press) begin
                  y_q   <= io.sw_data;
                  state <= START;
               end
            end
            START: begin
               led_q <= x_q;
               state <= BUSY;
            end
            BUSY: begin
               if (io.done) begin
                  // led_q doubles as the stored x2 while in SHOW_X
                  led_q <= io.res_x;
                  ry_q  <= io.res_y;
                  state <= SHOW_X;
               end
            end
            SHOW_X: begin
               if (press) begin
                  led_q <= ry_q;
                  state <= WAIT_X;
               end
            end
            default: state <= WAIT_X;
         endcase
      end
   end

   assign io.x_out = x_q;
   assign io.y_out = y_q;
   assign io.start = (state == START);
   assign io.led   = led_q;
   assign io.phase = state;

endmodule
